dht11_sensor_emu: RTL and testbench

//  Responder end of the DHT11 single-wire protocol: emulates a DHT11 sensor on the FPGA so the host-side

---
 rtl/dht11_sensor_emu.sv | 241 ++++++++++++++++++++++++
 tb/tb_dht11_sensor_emu.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: waits for a host start pulse on the single-wire bus,
// answers with the response preamble and clocks out a 40-bit frame
// (four data bytes followed by their 8-bit sum). The line is only ever
// pulled low (drive_low_o) or released; the pad's pull-up provides the high.
module dht11_sensor_emu #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int START_MIN_US = 10000,
  parameter int RESP_WAIT_US = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 54,
  parameter int BIT0_HIGH_US = 26,
  parameter int BIT1_HIGH_US = 70,
  parameter int EOF_LOW_US   = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_i,
  output logic        drive_low_o,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        tx_done_o,
  output logic        err_short_o,
  output logic        err_collision_o
);

  localparam int CYC_PER_US    = CLK_FREQ / 1_000_000;
  localparam int START_MIN_CYC = CYC_PER_US * START_MIN_US;
  localparam int CNT_W         = $clog2(START_MIN_CYC + 1);

  // Each phase ends on the cycle its counter reaches length-1, so it lasts exactly its length.
  localparam logic [CNT_W-1:0] START_MIN_C    = CNT_W'(START_MIN_CYC);
  localparam logic [CNT_W-1:0] RESP_WAIT_LAST = CNT_W'(CYC_PER_US * RESP_WAIT_US - 1);
  localparam logic [CNT_W-1:0] RESP_LOW_LAST  = CNT_W'(CYC_PER_US * RESP_LOW_US - 1);
  localparam logic [CNT_W-1:0] RESP_HIGH_LAST = CNT_W'(CYC_PER_US * RESP_HIGH_US - 1);
  localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(CYC_PER_US * BIT_LOW_US - 1);
  localparam logic [CNT_W-1:0] BIT0_HIGH_LAST = CNT_W'(CYC_PER_US * BIT0_HIGH_US - 1);
  localparam logic [CNT_W-1:0] BIT1_HIGH_LAST = CNT_W'(CYC_PER_US * BIT1_HIGH_US - 1);
  localparam logic [CNT_W-1:0] EOF_LOW_LAST   = CNT_W'(CYC_PER_US * EOF_LOW_US - 1);
  // The synchronizer still shows our own drive for a few cycles after release.
  localparam logic [CNT_W-1:0] GUARD_C        = CNT_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_WAIT,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_EOF_LOW
  } state_t;

  logic             line_meta_q;
  logic             line_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_idx_q, bit_idx_d;
  logic [39:0]      frame_q, frame_d;
  logic             armed_q, armed_d;
  logic             drive_low_q, drive_low_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             err_short_q, err_short_d;
  logic             err_coll_q, err_coll_d;

  logic [7:0]       chk;
  logic [CNT_W-1:0] bit_high_last;
  logic             collide;

  assign chk           = data_i[31:24] + data_i[23:16] + data_i[15:8] + data_i[7:0];
  assign bit_high_last = frame_q[39] ? BIT1_HIGH_LAST : BIT0_HIGH_LAST;
  assign collide       = (cnt_q >= GUARD_C) && !line_s_q;

  // Two-flop synchronizer for the asynchronous pad; resets low so a stuck-low line never arms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_meta_q <= 1'b0;
      line_s_q    <= 1'b0;
    end else begin
      line_meta_q <= line_i;
      line_s_q    <= line_meta_q;
    end
  end

  // State, counter, frame shifter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '0;
      armed_q     <= 1'b0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_coll_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_q     <= frame_d;
      armed_q     <= armed_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      err_short_q <= err_short_d;
      err_coll_q  <= err_coll_d;
    end
  end

  // Next-state logic: phase sequencing, start qualification and collision abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    armed_d     = armed_q;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
    err_short_d = 1'b0;
    err_coll_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        armed_d = armed_q | line_s_q;
        if (armed_q && !line_s_q) begin
          state_d = ST_HOST_LOW;
          cnt_d   = '0;
        end
      end

      ST_HOST_LOW: begin
        if (!line_s_q) begin
          if (cnt_q != START_MIN_C) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q >= START_MIN_C) begin
          state_d = ST_RESP_WAIT;
          cnt_d   = '0;
          frame_d = {data_i, chk};
          busy_d  = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_short_d = 1'b1;
        end
      end

      ST_RESP_WAIT: begin
        if (cnt_q == RESP_WAIT_LAST) begin
          state_d = ST_RESP_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP_LOW: begin
        if (cnt_q == RESP_LOW_LAST) begin
          state_d = ST_RESP_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP_HIGH: begin
        if (collide) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          busy_d     = 1'b0;
          armed_d    = 1'b0;
          err_coll_d = 1'b1;
        end else if (cnt_q == RESP_HIGH_LAST) begin
          state_d   = ST_BIT_LOW;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BIT_LOW: begin
        if (cnt_q == BIT_LOW_LAST) begin
          state_d = ST_BIT_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BIT_HIGH: begin
        if (collide) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          busy_d     = 1'b0;
          armed_d    = 1'b0;
          err_coll_d = 1'b1;
        end else if (cnt_q == bit_high_last) begin
          cnt_d   = '0;
          frame_d = {frame_q[38:0], 1'b0};
          if (bit_idx_q == 6'd39) begin
            state_d = ST_EOF_LOW;
          end else begin
            state_d   = ST_BIT_LOW;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EOF_LOW: begin
        if (cnt_q == EOF_LOW_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          tx_done_d = 1'b1;
          busy_d    = 1'b0;
          armed_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    drive_low_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) ||
                  (state_d == ST_EOF_LOW);
  end

  assign drive_low_o     = drive_low_q;
  assign busy_o          = busy_q;
  assign tx_done_o       = tx_done_q;
  assign err_short_o     = err_short_q;
  assign err_collision_o = err_coll_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Testbench for dht11_sensor_emu. Runs at 1 MHz so one cycle is one
// microsecond and the phase lengths read directly as their us values; the
// start threshold is scaled to 1000 us so 1800/500-cycle host pulses stand in
// for the 18 ms / 5 ms cases. The bus is modelled as a wired-AND of host and DUT.
module tb_dht11_sensor_emu;

  localparam int CLK_FREQ     = 1_000_000;
  localparam int START_MIN_US = 1000;
  localparam int HOST_START   = 1800;
  localparam int HOST_SHORT   = 500;
  localparam int T_WAIT       = 30;
  localparam int T_RLOW       = 80;
  localparam int T_RHIGH      = 80;
  localparam int T_BLOW       = 54;
  localparam int T_B0         = 26;
  localparam int T_B1         = 70;
  localparam int T_EOF        = 50;
  localparam int RUN_LIMIT    = 3000;

  logic        clk = 1'b0;
  logic        resetN;
  logic        hostLow;
  logic [31:0] dataIn;
  logic        lineIn;
  logic        driveLow;
  logic        busy;
  logic        txDone;
  logic        errShort;
  logic        errColl;

  int errors = 0;
  int checks = 0;

  int driveHighCnt = 0;
  int busyHighCnt  = 0;
  int txDoneCnt    = 0;
  int errShortCnt  = 0;
  int errCollCnt   = 0;

  logic [39:0] capBits;
  int          capWait, capRLow, capRHigh, capEof;
  int          lowMin, lowMax, hi0Min, hi0Max, hi1Min, hi1Max;
  logic        capDoneEnd, capBusyEnd, capDoneNext;
  bit          capTimeout;

  assign lineIn = ~(hostLow | driveLow);

  dht11_sensor_emu #(
    .CLK_FREQ    (CLK_FREQ),
    .START_MIN_US(START_MIN_US)
  ) dut (
    .clk            (clk),
    .reset_n        (resetN),
    .line_i         (lineIn),
    .drive_low_o    (driveLow),
    .data_i         (dataIn),
    .busy_o         (busy),
    .tx_done_o      (txDone),
    .err_short_o    (errShort),
    .err_collision_o(errColl)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Activity counters sampled mid-cycle, used to prove pulses and absence of activity.
  always @(negedge clk) begin
    if (driveLow === 1'b1) driveHighCnt++;
    if (busy === 1'b1)     busyHighCnt++;
    if (txDone === 1'b1)   txDoneCnt++;
    if (errShort === 1'b1) errShortCnt++;
    if (errColl === 1'b1)  errCollCnt++;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic measureRun(input logic level, output int len);
    len = 0;
    if (!capTimeout) begin
      while (driveLow === level && len < RUN_LIMIT) begin
        len++;
        @(negedge clk);
      end
      if (len >= RUN_LIMIT) capTimeout = 1;
    end
  endtask

  task automatic waitBusy();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b1 && n < RUN_LIMIT) begin
      n++;
      @(negedge clk);
    end
    if (busy !== 1'b1) capTimeout = 1;
  endtask

  task automatic hostPulse(input int n);
    repeat (10) @(negedge clk);
    hostLow = 1'b1;
    repeat (n) @(negedge clk);
    hostLow = 1'b0;
  endtask

  task automatic captureFrame();
    int len;
    capTimeout = 0;
    capBits = '0;
    lowMin = RUN_LIMIT; lowMax = 0;
    hi0Min = RUN_LIMIT; hi0Max = 0;
    hi1Min = RUN_LIMIT; hi1Max = 0;
    waitBusy();
    measureRun(1'b0, capWait);
    measureRun(1'b1, capRLow);
    measureRun(1'b0, capRHigh);
    for (int i = 0; i < 40; i++) begin
      measureRun(1'b1, len);
      if (len < lowMin) lowMin = len;
      if (len > lowMax) lowMax = len;
      measureRun(1'b0, len);
      if (len > (T_B0 + T_B1) / 2) begin
        capBits = {capBits[38:0], 1'b1};
        if (len < hi1Min) hi1Min = len;
        if (len > hi1Max) hi1Max = len;
      end else begin
        capBits = {capBits[38:0], 1'b0};
        if (len < hi0Min) hi0Min = len;
        if (len > hi0Max) hi0Max = len;
      end
    end
    measureRun(1'b1, capEof);
    capDoneEnd = txDone;
    capBusyEnd = busy;
    @(negedge clk);
    capDoneNext = txDone;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    hostLow = 1'b0;
    dataIn = '0;
    repeat (3) @(negedge clk);
    checks++; if (driveLow !== 1'b0) begin errors++; $display("[TB] FAIL reset_drive got=%b exp=0", driveLow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (txDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_txdone got=%b exp=0", txDone); end
    checks++; if (errShort !== 1'b0) begin errors++; $display("[TB] FAIL reset_errshort got=%b exp=0", errShort); end
    checks++; if (errColl !== 1'b0) begin errors++; $display("[TB] FAIL reset_errcoll got=%b exp=0", errColl); end
    resetN = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame();
    int txBefore;
    $display("[TB] frame 0x35001800");
    dataIn = 32'h3500_1800;
    txBefore = txDoneCnt;
    hostPulse(HOST_START);
    captureFrame();
    checks++; if (capTimeout !== 1'b0) begin errors++; $display("[TB] FAIL frame_timeout got=%b exp=0", capTimeout); end
    checks++; if (capWait !== T_WAIT) begin errors++; $display("[TB] FAIL frame_resp_wait got=%0d exp=%0d", capWait, T_WAIT); end
    checks++; if (capRLow !== T_RLOW) begin errors++; $display("[TB] FAIL frame_resp_low got=%0d exp=%0d", capRLow, T_RLOW); end
    checks++; if (capRHigh !== T_RHIGH) begin errors++; $display("[TB] FAIL frame_resp_high got=%0d exp=%0d", capRHigh, T_RHIGH); end
    checks++; if (capBits !== 40'h35_0018_004D) begin errors++; $display("[TB] FAIL frame_bits got=%h exp=350018004d", capBits); end
    checks++; if (capEof !== T_EOF) begin errors++; $display("[TB] FAIL frame_eof got=%0d exp=%0d", capEof, T_EOF); end
    checks++; if (capDoneEnd !== 1'b1) begin errors++; $display("[TB] FAIL frame_txdone got=%b exp=1", capDoneEnd); end
    checks++; if (capBusyEnd !== 1'b0) begin errors++; $display("[TB] FAIL frame_busy_end got=%b exp=0", capBusyEnd); end
    checks++; if (capDoneNext !== 1'b0) begin errors++; $display("[TB] FAIL frame_txdone_width got=%b exp=0", capDoneNext); end
    checks++; if (txDoneCnt - txBefore !== 1) begin errors++; $display("[TB] FAIL frame_txdone_count got=%0d exp=1", txDoneCnt - txBefore); end
  endtask

  // Also re-pulses the host low inside the response wait; the frame must carry on unchanged.
  task automatic test_bit_timing();
    $display("[TB] bit timing 0xFF00FF00 with host re-pulse");
    dataIn = 32'hFF00_FF00;
    hostPulse(HOST_START);
    fork
      begin
        for (int k = 0; k < RUN_LIMIT && busy !== 1'b1; k++) @(negedge clk);
        if (busy === 1'b1) begin
          repeat (5) @(negedge clk);
          hostLow = 1'b1;
          repeat (10) @(negedge clk);
          hostLow = 1'b0;
        end
      end
    join_none
    captureFrame();
    checks++; if (capTimeout !== 1'b0) begin errors++; $display("[TB] FAIL timing_timeout got=%b exp=0", capTimeout); end
    checks++; if (capBits !== 40'hFF_00FF_00FE) begin errors++; $display("[TB] FAIL timing_bits got=%h exp=ff00ff00fe", capBits); end
    checks++; if (capWait !== T_WAIT || capRHigh !== T_RHIGH) begin errors++; $display("[TB] FAIL timing_repulse got=%0d/%0d exp=%0d/%0d", capWait, capRHigh, T_WAIT, T_RHIGH); end
    checks++; if (lowMin !== T_BLOW || lowMax !== T_BLOW) begin errors++; $display("[TB] FAIL timing_bit_low got=%0d..%0d exp=%0d", lowMin, lowMax, T_BLOW); end
    checks++; if (hi1Min !== T_B1 || hi1Max !== T_B1) begin errors++; $display("[TB] FAIL timing_bit1_high got=%0d..%0d exp=%0d", hi1Min, hi1Max, T_B1); end
    checks++; if (hi0Min !== T_B0 || hi0Max !== T_B0) begin errors++; $display("[TB] FAIL timing_bit0_high got=%0d..%0d exp=%0d", hi0Min, hi0Max, T_B0); end
    checks++; if (capDoneEnd !== 1'b1) begin errors++; $display("[TB] FAIL timing_txdone got=%b exp=1", capDoneEnd); end
  endtask

  task automatic test_short_start();
    int shortBefore, driveBefore, busyBefore;
    $display("[TB] short host pulse");
    shortBefore = errShortCnt;
    driveBefore = driveHighCnt;
    busyBefore  = busyHighCnt;
    hostPulse(HOST_SHORT);
    repeat (50) @(negedge clk);
    checks++; if (errShortCnt - shortBefore !== 1) begin errors++; $display("[TB] FAIL short_err_pulse got=%0d exp=1", errShortCnt - shortBefore); end
    checks++; if (driveHighCnt - driveBefore !== 0) begin errors++; $display("[TB] FAIL short_drive got=%0d exp=0", driveHighCnt - driveBefore); end
    checks++; if (busyHighCnt - busyBefore !== 0) begin errors++; $display("[TB] FAIL short_busy got=%0d exp=0", busyHighCnt - busyBefore); end
  endtask

  // data_in is cleared right after the snapshot; the frame must still carry the old bytes.
  task automatic test_checksum_wrap();
    $display("[TB] checksum wrap 0xFFFFFFFF");
    dataIn = 32'hFFFF_FFFF;
    hostPulse(HOST_START);
    fork
      begin
        for (int k = 0; k < RUN_LIMIT && busy !== 1'b1; k++) @(negedge clk);
        dataIn = 32'h0000_0000;
      end
    join_none
    captureFrame();
    checks++; if (capTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wrap_timeout got=%b exp=0", capTimeout); end
    checks++; if (capBits !== 40'hFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_bits got=%h exp=fffffffffc", capBits); end
    checks++; if (capDoneEnd !== 1'b1) begin errors++; $display("[TB] FAIL wrap_txdone got=%b exp=1", capDoneEnd); end
  endtask

  task automatic test_collision();
    int len, collBefore, busyBefore;
    bit seen;
    $display("[TB] collision in bit 3 high phase");
    dataIn = 32'h3500_1800;
    collBefore = errCollCnt;
    hostPulse(HOST_START);
    capTimeout = 0;
    waitBusy();
    measureRun(1'b0, len);
    measureRun(1'b1, len);
    measureRun(1'b0, len);
    for (int i = 0; i < 3; i++) begin
      measureRun(1'b1, len);
      measureRun(1'b0, len);
    end
    measureRun(1'b1, len);
    repeat (10) @(negedge clk);
    hostLow = 1'b1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (errColl === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL coll_pulse got=%b exp=1", seen); end
    checks++; if (driveLow !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL coll_release got=drive%b/busy%b exp=0/0", driveLow, busy); end
    @(negedge clk);
    checks++; if (errColl !== 1'b0) begin errors++; $display("[TB] FAIL coll_pulse_width got=%b exp=0", errColl); end
    repeat (88) @(negedge clk);
    hostLow = 1'b0;
    busyBefore = busyHighCnt;
    repeat (50) @(negedge clk);
    checks++; if (busyHighCnt - busyBefore !== 0) begin errors++; $display("[TB] FAIL coll_idle got=%0d exp=0", busyHighCnt - busyBefore); end
    checks++; if (errCollCnt - collBefore !== 1) begin errors++; $display("[TB] FAIL coll_count got=%0d exp=1", errCollCnt - collBefore); end
    dataIn = 32'h0102_0304;
    hostPulse(HOST_START);
    captureFrame();
    checks++; if (capTimeout !== 1'b0) begin errors++; $display("[TB] FAIL coll_restart_timeout got=%b exp=0", capTimeout); end
    checks++; if (capBits !== 40'h01_0203_040A) begin errors++; $display("[TB] FAIL coll_restart_bits got=%h exp=010203040a", capBits); end
  endtask

  task automatic test_reset_mid_frame();
    int len, busyBefore, driveBefore, txBefore, shortBefore;
    $display("[TB] reset during bit 10");
    dataIn = 32'h1234_5678;
    hostPulse(HOST_START);
    capTimeout = 0;
    waitBusy();
    measureRun(1'b0, len);
    measureRun(1'b1, len);
    measureRun(1'b0, len);
    for (int i = 0; i < 10; i++) begin
      measureRun(1'b1, len);
      measureRun(1'b0, len);
    end
    repeat (10) @(negedge clk);
    checks++; if (driveLow !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_bit_low got=%b exp=1", driveLow); end
    hostLow = 1'b1;
    resetN = 1'b0;
    #1;
    checks++; if (driveLow !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async got=drive%b/busy%b exp=0/0", driveLow, busy); end
    busyBefore  = busyHighCnt;
    driveBefore = driveHighCnt;
    txBefore    = txDoneCnt;
    shortBefore = errShortCnt;
    repeat (5) @(negedge clk);
    resetN = 1'b1;
    repeat (1500) @(negedge clk);
    hostLow = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (busyHighCnt - busyBefore !== 0 || driveHighCnt - driveBefore !== 0) begin errors++; $display("[TB] FAIL midrst_unarmed got=busy%0d/drive%0d exp=0/0", busyHighCnt - busyBefore, driveHighCnt - driveBefore); end
    checks++; if (txDoneCnt - txBefore !== 0) begin errors++; $display("[TB] FAIL midrst_no_txdone got=%0d exp=0", txDoneCnt - txBefore); end
    checks++; if (errShortCnt - shortBefore !== 0) begin errors++; $display("[TB] FAIL midrst_no_errshort got=%0d exp=0", errShortCnt - shortBefore); end
    hostPulse(HOST_START);
    captureFrame();
    checks++; if (capTimeout !== 1'b0) begin errors++; $display("[TB] FAIL midrst_restart_timeout got=%b exp=0", capTimeout); end
    checks++; if (capBits !== 40'h12_3456_7814) begin errors++; $display("[TB] FAIL midrst_restart_bits got=%h exp=1234567814", capBits); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_frame();
    test_bit_timing();
    test_short_start();
    test_checksum_wrap();
    test_collision();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
